instr_exec: RTL and testbench

INSTR_EXEC -- requirements
Module: instr_exec

---
 rtl/instr_exec.sv | 121 ++++++++++++
 tb/tb_instr_exec.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/instr_exec.sv
// Two-stage (decode register + execute) accumulator machine with JNZ squash and sticky HALT.
// Optional build macro EXEC_SAT_EN: ADD saturates at 8'hFF and DEC at 8'h00 instead of wrapping.
module instr_exec (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  instruction,
   input  logic        instr_valid,
   output logic        pc_load,
   output logic [4:0]  pc_target,
   output logic [7:0]  acc,
   output logic        flag_z,
   output logic        halted,
   output logic [15:0] exec_count
);

   localparam logic [1:0] OP_LDI = 2'b00;
   localparam logic [1:0] OP_ADD = 2'b01;
   localparam logic [1:0] OP_JNZ = 2'b10;
   localparam logic [1:0] OP_SYS = 2'b11;

   logic [5:0]  d_instr_q;
   logic        d_vld_q;
   logic [1:0]  kill_q, kill_d;
   logic [7:0]  acc_q, acc_d;
   logic        z_q, z_d;
   logic        halt_q, halt_d;
   logic        pcl_q, pcl_d;
   logic [4:0]  pct_q, pct_d;
   logic [15:0] cnt_q, cnt_d;

   logic [1:0]  op;
   logic [3:0]  imm;
   logic [7:0]  add_res, dec_res;
   logic        live, exec_en, squash;

   assign op  = d_instr_q[5:4];
   assign imm = d_instr_q[3:0];

`ifdef EXEC_SAT_EN
   logic [8:0] sum9;
   assign sum9    = {1'b0, acc_q} + {5'b0, imm};
   assign add_res = sum9[8] ? 8'hFF : sum9[7:0];
   assign dec_res = (acc_q == 8'h00) ? 8'h00 : acc_q - 8'd1;
`else
   assign add_res = acc_q + {4'b0, imm};
   assign dec_res = acc_q - 8'd1;
`endif

   // Bubbles and anything after HALT neither execute nor consume the kill count.
   assign live    = d_vld_q && !halt_q;
   assign exec_en = live && (kill_q == 2'd0);
   assign squash  = live && (kill_q != 2'd0);

   always_comb begin
      acc_d  = acc_q;
      halt_d = halt_q;
      pcl_d  = 1'b0;
      pct_d  = pct_q;
      kill_d = kill_q;
      cnt_d  = cnt_q;
      if (squash)
         kill_d = kill_q - 2'd1;
      if (exec_en) begin
         if (cnt_q != 16'hFFFF)
            cnt_d = cnt_q + 16'd1;
         case (op)
            OP_LDI: acc_d = {4'b0, imm};
            OP_ADD: acc_d = add_res;
            OP_JNZ: begin
               if (!z_q) begin
                  pcl_d  = 1'b1;
                  pct_d  = {1'b0, imm};
                  kill_d = 2'd2;
               end
            end
            OP_SYS: begin
               case (imm)
                  4'b0001: halt_d = 1'b1;
                  4'b0010: acc_d  = dec_res;
                  4'b0011: acc_d  = 8'h00;
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
      z_d = (acc_d == 8'h00);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         d_instr_q <= 6'd0;
         d_vld_q   <= 1'b0;
         kill_q    <= 2'd0;
         acc_q     <= 8'h00;
         z_q       <= 1'b1;
         halt_q    <= 1'b0;
         pcl_q     <= 1'b0;
         pct_q     <= 5'd0;
         cnt_q     <= 16'd0;
      end else begin
         d_instr_q <= instruction;
         d_vld_q   <= instr_valid;
         kill_q    <= kill_d;
         acc_q     <= acc_d;
         z_q       <= z_d;
         halt_q    <= halt_d;
         pcl_q     <= pcl_d;
         pct_q     <= pct_d;
         cnt_q     <= cnt_d;
      end
   end

   assign pc_load    = pcl_q;
   assign pc_target  = pct_q;
   assign acc        = acc_q;
   assign flag_z     = z_q;
   assign halted     = halt_q;
   assign exec_count = cnt_q;

endmodule

// File: tb/tb_instr_exec.sv
// Directed bench for instr_exec: hand-computed expectations checked with immediate assertions.
module tb_instr_exec;
   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  instruction;
   logic        instr_valid;
   logic        pc_load;
   logic [4:0]  pc_target;
   logic [7:0]  acc;
   logic        flag_z;
   logic        halted;
   logic [15:0] exec_count;

   int total = 0;
   int bad   = 0;

   instr_exec dut (
      .clk(clk), .rst(rst), .instruction(instruction), .instr_valid(instr_valid),
      .pc_load(pc_load), .pc_target(pc_target), .acc(acc), .flag_z(flag_z),
      .halted(halted), .exec_count(exec_count)
   );

   always #5 clk = ~clk;

   localparam logic [5:0] LDI0  = 6'b00_0000;
   localparam logic [5:0] LDI1  = 6'b00_0001;
   localparam logic [5:0] LDI2  = 6'b00_0010;
   localparam logic [5:0] LDI5  = 6'b00_0101;
   localparam logic [5:0] LDI7  = 6'b00_0111;
   localparam logic [5:0] LDI9  = 6'b00_1001;
   localparam logic [5:0] LDI15 = 6'b00_1111;
   localparam logic [5:0] ADD1  = 6'b01_0001;
   localparam logic [5:0] ADD2  = 6'b01_0010;
   localparam logic [5:0] ADD3  = 6'b01_0011;
   localparam logic [5:0] ADD15 = 6'b01_1111;
   localparam logic [5:0] JNZ3  = 6'b10_0011;
   localparam logic [5:0] JNZ4  = 6'b10_0100;
   localparam logic [5:0] JNZ7  = 6'b10_0111;
   localparam logic [5:0] JNZ9  = 6'b10_1001;
   localparam logic [5:0] HALT  = 6'b11_0001;
   localparam logic [5:0] DEC   = 6'b11_0010;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present one input word, then move just past the next rising edge.
   task automatic tick(input logic [5:0] ins, input logic v);
      instruction = ins;
      instr_valid = v;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      instr_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      instruction = 6'd0;
      instr_valid = 1'b0;

      // Reset state
      do_reset();
      check("rst_acc", 16'(acc), 16'h00);
      check("rst_z", 16'(flag_z), 16'h1);
      check("rst_halt", 16'(halted), 16'h0);
      check("rst_pcl", 16'(pc_load), 16'h0);
      check("rst_pct", 16'(pc_target), 16'h0);
      check("rst_cnt", exec_count, 16'h0);

      // LDI 5, ADD 3
      tick(LDI5, 1'b1);
      tick(ADD3, 1'b1);
      check("ldi5_acc", 16'(acc), 16'h05);
      tick(6'd0, 1'b0);
      check("add_acc", 16'(acc), 16'h08);
      check("add_z", 16'(flag_z), 16'h0);
      check("add_cnt", exec_count, 16'd2);

      // LDI 0, JNZ 7 -> not taken
      do_reset();
      tick(LDI0, 1'b1);
      tick(JNZ7, 1'b1);
      check("ldi0_z", 16'(flag_z), 16'h1);
      tick(6'd0, 1'b0);
      check("nt_pcl", 16'(pc_load), 16'h0);
      check("nt_cnt", exec_count, 16'd2);
      tick(6'd0, 1'b0);
      check("nt_pcl2", 16'(pc_load), 16'h0);

      // LDI 1, JNZ 9, ADD 1, ADD 1, ADD 2 -> taken, two squashed
      do_reset();
      tick(LDI1, 1'b1);
      tick(JNZ9, 1'b1);
      tick(ADD1, 1'b1);
      check("tk_pcl", 16'(pc_load), 16'h1);
      check("tk_pct", 16'(pc_target), 16'd9);
      tick(ADD1, 1'b1);
      check("tk_pcl_drop", 16'(pc_load), 16'h0);
      check("tk_sq1_acc", 16'(acc), 16'h01);
      tick(ADD2, 1'b1);
      check("tk_sq2_acc", 16'(acc), 16'h01);
      tick(6'd0, 1'b0);
      check("tk_acc", 16'(acc), 16'h03);
      check("tk_cnt", exec_count, 16'd3);
      check("tk_pcl_end", 16'(pc_load), 16'h0);

      // Same with a bubble inside the squash window: bubble must not consume a kill
      do_reset();
      tick(LDI1, 1'b1);
      tick(JNZ9, 1'b1);
      tick(ADD1, 1'b1);
      tick(6'd0, 1'b0);
      tick(ADD1, 1'b1);
      tick(ADD2, 1'b1);
      tick(6'd0, 1'b0);
      tick(6'd0, 1'b0);
      check("bub_acc", 16'(acc), 16'h03);
      check("bub_cnt", exec_count, 16'd3);

      // LDI 15, ADD 15, ADD 15, DEC -> 44
      do_reset();
      tick(LDI15, 1'b1);
      tick(ADD15, 1'b1);
      tick(ADD15, 1'b1);
      tick(DEC, 1'b1);
      check("sum45", 16'(acc), 16'd45);
      tick(6'd0, 1'b0);
      check("dec44", 16'(acc), 16'h2C);
      check("dec_cnt", exec_count, 16'd4);

      // LDI 0, DEC, ADD 2: wrap vs saturate
      do_reset();
      tick(LDI0, 1'b1);
      tick(DEC, 1'b1);
      tick(ADD2, 1'b1);
`ifdef EXEC_SAT_EN
      check("dec0_acc", 16'(acc), 16'h00);
      check("dec0_z", 16'(flag_z), 16'h1);
`else
      check("dec0_acc", 16'(acc), 16'hFF);
      check("dec0_z", 16'(flag_z), 16'h0);
`endif
      tick(6'd0, 1'b0);
`ifdef EXEC_SAT_EN
      check("add_after_dec", 16'(acc), 16'h02);
`else
      check("add_after_dec", 16'(acc), 16'h01);
`endif

      // LDI 7, HALT, LDI 9, JNZ 3 -> frozen after HALT
      do_reset();
      tick(LDI7, 1'b1);
      tick(HALT, 1'b1);
      tick(LDI9, 1'b1);
      check("halt_set", 16'(halted), 16'h1);
      check("halt_cnt", exec_count, 16'd2);
      tick(JNZ3, 1'b1);
      tick(6'd0, 1'b0);
      check("halt_acc", 16'(acc), 16'h07);
      check("halt_cnt_frz", exec_count, 16'd2);
      check("halt_pcl", 16'(pc_load), 16'h0);
      tick(6'd0, 1'b0);
      check("halt_sticky", 16'(halted), 16'h1);
      check("halt_pcl2", 16'(pc_load), 16'h0);
      do_reset();
      check("unhalt", 16'(halted), 16'h0);
      check("unhalt_acc", 16'(acc), 16'h00);
      check("unhalt_z", 16'(flag_z), 16'h1);

      // Reset right after a taken JNZ discards pc_load and the pending squash
      do_reset();
      tick(LDI1, 1'b1);
      tick(JNZ4, 1'b1);
      tick(ADD1, 1'b1);
      check("pre_rst_pcl", 16'(pc_load), 16'h1);
      do_reset();
      check("post_rst_pcl", 16'(pc_load), 16'h0);
      tick(LDI2, 1'b1);
      tick(6'd0, 1'b0);
      check("post_rst_acc", 16'(acc), 16'h02);
      check("post_rst_cnt", exec_count, 16'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
